// File: rtl/julia_frame_ctrl_if.sv
// rtl/julia_frame_ctrl_if.sv - parameter-update request channel into julia_frame_ctrl
interface julia_frame_ctrl_if;
    logic               req_valid;
    logic               req_ready;
    logic signed [17:0] c_real_in;
    logic signed [17:0] c_comp_in;
    logic signed [17:0] x_in;
    logic signed [17:0] y_in;
    logic signed [17:0] scale_in;

    modport master (
        output req_valid, c_real_in, c_comp_in, x_in, y_in, scale_in,
        input  req_ready
    );

    modport slave (
        input  req_valid, c_real_in, c_comp_in, x_in, y_in, scale_in,
        output req_ready
    );
endinterface

// File: rtl/julia_frame_ctrl.sv
// rtl/julia_frame_ctrl.sv - Julia renderer frame scheduler: launch, completion tracking, render timing
// Optional auto-animation in IDLE is enabled by defining JULIA_AUTO_ANIMATE_EN.
module julia_frame_ctrl #(
    parameter int                 NUM_STRIPES = 2,
    parameter logic signed [17:0] ANIM_STEP   = 18'sd16
) (
    input  logic                   clock,
    input  logic                   reset,
    julia_frame_ctrl_if.slave      req,
    output logic signed [17:0]     c_real_wire,
    output logic signed [17:0]     c_comp_wire,
    output logic signed [17:0]     x_wire,
    output logic signed [17:0]     y_wire,
    output logic signed [17:0]     scale_wire,
    output logic                   valid,
    output logic                   update,
    input  logic [NUM_STRIPES-1:0] stripe_pause,
    output logic                   frame_busy,
    output logic                   frame_done,
    output logic [31:0]            frame_cycles,
    output logic [7:0]             abort_count
);
    localparam logic signed [17:0] RST_C_REAL = -18'sd13107;
    localparam logic signed [17:0] RST_C_COMP = 18'sd2556;
    localparam logic signed [17:0] RST_SCALE  = 18'sd32768;

    typedef enum logic [1:0] {S_SETTLE, S_RUN, S_IDLE, S_LAUNCH} state_t;

    state_t             state_q, state_d;
    logic signed [17:0] c_real_q, c_real_d, c_comp_q, c_comp_d;
    logic signed [17:0] x_q, x_d, y_q, y_d, scale_q, scale_d;
    logic [31:0]        cnt_q, cnt_d, cnt_inc;
    logic [31:0]        cycles_q, cycles_d;
    logic [7:0]         abort_q, abort_d;
    logic               valid_q, valid_d, done_q, done_d;
    logic               busy_q, busy_d, ready_q, ready_d;
    logic               accept, all_paused;

`ifdef JULIA_AUTO_ANIMATE_EN
    logic signed [18:0] anim_sum;
    logic signed [17:0] anim_next;
    always_comb begin
        anim_sum  = {c_real_q[17], c_real_q} + {ANIM_STEP[17], ANIM_STEP};
        anim_next = (anim_sum > 19'sd16384) ? -18'sd16384 : anim_sum[17:0];
    end
`endif

    assign accept     = req.req_valid && ready_q;
    assign all_paused = &stripe_pause;
    assign cnt_inc    = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

    always_comb begin
        state_d  = state_q;
        c_real_d = c_real_q;
        c_comp_d = c_comp_q;
        x_d      = x_q;
        y_d      = y_q;
        scale_d  = scale_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        abort_d  = abort_q;
        done_d   = 1'b0;

        if (accept) begin
            c_real_d = req.c_real_in;
            c_comp_d = req.c_comp_in;
            x_d      = req.x_in;
            y_d      = req.y_in;
            scale_d  = req.scale_in;
            state_d  = S_LAUNCH;
        end

        case (state_q)
            S_LAUNCH: begin
                cnt_d   = 32'd0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // stripes still show last frame's pause for one cycle after update
                cnt_d   = cnt_inc;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                if (accept) begin
                    if (!all_paused)
                        abort_d = (abort_q == 8'hFF) ? abort_q : abort_q + 8'd1;
                end else if (all_paused) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    cycles_d = cnt_inc;
                end
            end
            S_IDLE: begin
`ifdef JULIA_AUTO_ANIMATE_EN
                if (!accept) begin
                    c_real_d = anim_next;
                    state_d  = S_LAUNCH;
                end
`endif
            end
            default: state_d = S_SETTLE;
        endcase

        valid_d = (state_d == S_LAUNCH);
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE) || (state_d == S_RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_SETTLE;
            c_real_q <= RST_C_REAL;
            c_comp_q <= RST_C_COMP;
            x_q      <= '0;
            y_q      <= '0;
            scale_q  <= RST_SCALE;
            cnt_q    <= '0;
            cycles_q <= '0;
            abort_q  <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_real_q <= c_real_d;
            c_comp_q <= c_comp_d;
            x_q      <= x_d;
            y_q      <= y_d;
            scale_q  <= scale_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            abort_q  <= abort_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign req.req_ready  = ready_q;
    assign c_real_wire    = c_real_q;
    assign c_comp_wire    = c_comp_q;
    assign x_wire         = x_q;
    assign y_wire         = y_q;
    assign scale_wire     = scale_q;
    assign valid          = valid_q;
    assign update         = valid_q;
    assign frame_busy     = busy_q;
    assign frame_done     = done_q;
    assign frame_cycles   = cycles_q;
    assign abort_count    = abort_q;
endmodule

// File: tb/tb_julia_frame_ctrl.sv
// tb/tb_julia_frame_ctrl.sv - self-checking bench for julia_frame_ctrl with a timing-rule model
module tb_julia_frame_ctrl;
    localparam int                 NS   = 2;
    localparam logic signed [17:0] STEP = 18'sd16;

    logic               clock = 1'b0;
    logic               reset;
    logic [NS-1:0]      stripe_pause;
    logic signed [17:0] c_real_wire, c_comp_wire, x_wire, y_wire, scale_wire;
    logic               valid, update, frame_busy, frame_done;
    logic [31:0]        frame_cycles;
    logic [7:0]         abort_count;

    julia_frame_ctrl_if rif();

    julia_frame_ctrl #(.NUM_STRIPES(NS), .ANIM_STEP(STEP)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (rif),
        .c_real_wire  (c_real_wire),
        .c_comp_wire  (c_comp_wire),
        .x_wire       (x_wire),
        .y_wire       (y_wire),
        .scale_wire   (scale_wire),
        .valid        (valid),
        .update       (update),
        .stripe_pause (stripe_pause),
        .frame_busy   (frame_busy),
        .frame_done   (frame_done),
        .frame_cycles (frame_cycles),
        .abort_count  (abort_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, logic signed [63:0] act, logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Model: outputs follow from the cycle distance to the last launch edge.
    int  cyc = 0;
    int  launch_t = 0;
    bit  busy = 1'b0;
    bit  started = 1'b0;
    int  e_c_real, e_c_comp, e_x, e_y, e_scale;
    int  e_cycles, e_abort;
    bit  e_valid, e_done, e_busy, e_ready;

    always @(posedge clock) begin : model
        int age;
        int s;
        bit acc;
        bit allp;
        cyc++;
        e_valid = 1'b0;
        e_done  = 1'b0;
        if (reset) begin
            e_c_real = -13107; e_c_comp = 2556; e_x = 0; e_y = 0; e_scale = 32768;
            e_cycles = 0; e_abort = 0;
            busy     = 1'b1;
            launch_t = cyc - 1;
            started  = 1'b1;
        end else if (started) begin
            acc  = rif.req_valid && e_ready;
            allp = &stripe_pause;
            age  = cyc - launch_t;
            if (acc) begin
                if (busy && !allp && e_abort < 255) e_abort++;
                e_c_real = rif.c_real_in; e_c_comp = rif.c_comp_in;
                e_x = rif.x_in; e_y = rif.y_in; e_scale = rif.scale_in;
                launch_t = cyc; busy = 1'b1; e_valid = 1'b1;
            end else if (busy && age >= 3 && allp) begin
                e_done = 1'b1; e_cycles = age - 1; busy = 1'b0;
            end
`ifdef JULIA_AUTO_ANIMATE_EN
            else if (!busy) begin
                s = e_c_real + int'(STEP);
                e_c_real = (s > 16384) ? -16384 : s;
                launch_t = cyc; busy = 1'b1; e_valid = 1'b1;
            end
`endif
        end
        e_busy  = busy;
        e_ready = !busy || ((cyc - launch_t) >= 2);
    end

    always @(negedge clock) begin
        if (started) begin
            chk("c_real", c_real_wire, e_c_real);
            chk("c_comp", c_comp_wire, e_c_comp);
            chk("x", x_wire, e_x);
            chk("y", y_wire, e_y);
            chk("scale", scale_wire, e_scale);
            chk("valid", valid, e_valid);
            chk("update", update, e_valid);
            chk("busy", frame_busy, e_busy);
            chk("ready", rif.req_ready, e_ready);
            chk("done", frame_done, e_done);
            chk("cycles", frame_cycles, e_cycles);
            chk("abort", abort_count, e_abort);
        end
    end

    task automatic send_req(input int cr, input int cc, input int x, input int y, input int sc);
        logic [31:0] v;
        int n;
        n = 0;
        while (rif.req_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) chk("req_ready_timeout", 0, 1);
        v = cr; rif.c_real_in = v[17:0];
        v = cc; rif.c_comp_in = v[17:0];
        v = x;  rif.x_in      = v[17:0];
        v = y;  rif.y_in      = v[17:0];
        v = sc; rif.scale_in  = v[17:0];
        rif.req_valid = 1'b1;
        @(negedge clock);
        rif.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (frame_done !== 1'b1 && n < 300);
        if (frame_done !== 1'b1) chk("done_timeout", 0, 1);
    endtask

    initial begin
        reset = 1'b1;
        stripe_pause = 2'b00;
        rif.req_valid = 1'b0;
        rif.c_real_in = '0; rif.c_comp_in = '0; rif.x_in = '0; rif.y_in = '0; rif.scale_in = '0;
        repeat (3) @(negedge clock);
        chk("lit_rst_c_real", c_real_wire, -13107);
        chk("lit_rst_c_comp", c_comp_wire, 2556);
        chk("lit_rst_scale", scale_wire, 32768);
        chk("lit_rst_busy", frame_busy, 1);
        chk("lit_rst_ready", rif.req_ready, 0);
        reset = 1'b0;

        repeat (20) @(negedge clock);
        stripe_pause = 2'b11;
        wait_done();
        chk("lit_reset_frame_cycles", frame_cycles, 21);
        chk("lit_reset_frame_c_real", c_real_wire, -13107);

        stripe_pause = 2'b00;
        send_req(1000, -500, 123, -77, 16384);
        chk("lit_launch_c_real", c_real_wire, 1000);
        chk("lit_launch_scale", scale_wire, 16384);
        chk("lit_launch_valid", valid, 1);
        chk("lit_launch_ready", rif.req_ready, 0);
        @(negedge clock);
        chk("lit_settle_valid", valid, 0);
        chk("lit_settle_ready", rif.req_ready, 0);
        @(negedge clock);
        chk("lit_run_ready", rif.req_ready, 1);
        repeat (47) @(negedge clock);
        stripe_pause = 2'b11;
        wait_done();
        chk("lit_frame_cycles_49", frame_cycles, 49);

        send_req(2000, 100, 0, 0, 8192);
        chk("lit_stale_done0", frame_done, 0);
        @(negedge clock);
        chk("lit_stale_done1", frame_done, 0);
        @(negedge clock);
        chk("lit_stale_done2", frame_done, 0);
        @(negedge clock);
        chk("lit_stale_done3", frame_done, 1);
        chk("lit_stale_cycles", frame_cycles, 2);

        stripe_pause = 2'b01;
        send_req(3000, 1, 2, 3, 4096);
        repeat (4) @(negedge clock);
        send_req(4000, 5, 6, 7, 4096);
        chk("lit_abort_count", abort_count, 1);
        chk("lit_abort_c_real", c_real_wire, 4000);
        chk("lit_abort_done", frame_done, 0);

        repeat (2) @(negedge clock);
        stripe_pause = 2'b11;
        send_req(5000, 8, 9, 10, 2048);
        chk("lit_coinc_abort", abort_count, 1);
        chk("lit_coinc_c_real", c_real_wire, 5000);
        chk("lit_coinc_done", frame_done, 0);
        wait_done();
        chk("lit_coinc_cycles", frame_cycles, 2);

        send_req(16380, 0, 0, 0, 32768);
        wait_done();
`ifdef JULIA_AUTO_ANIMATE_EN
        @(negedge clock);
        chk("lit_anim_valid", valid, 1);
        chk("lit_anim_c_real", c_real_wire, -16384);
`else
        repeat (10) @(negedge clock);
        chk("lit_idle_busy", frame_busy, 0);
        chk("lit_idle_c_real", c_real_wire, 16380);
        chk("lit_idle_valid", valid, 0);
`endif
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
